neuron_mac_controller: RTL and testbench

Downstream consumer of the ROM controller's word stream. On a start pulse it issues a burst of ROM reads for one neuron, and multiply-accumulates the returned packed weight/input pairs into a wide signed sum. It then applies a threshold activation and presents the sum and the 1-bit neuron output with a done pulse. It is the first compute stage of the network datapath.

---
 rtl/nn_pkg.sv | 20 ++
 rtl/mac_unit.sv | 43 ++++
 rtl/neuron_mac_controller.sv | 118 +++++++++++
 tb/tb_neuron_mac_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the neuron datapath.
// ROM words carry a packed Q8.8 weight/input pair, weight in the upper (MSB-first) half.
package nn_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned Q_W        = 16;
  localparam int unsigned FRAC_BITS  = 8;

  // Offsets in the MSB-first [0:WORD_W-1] view of a ROM word.
  localparam int unsigned WEIGHT_POS = 0;
  localparam int unsigned INPUT_POS  = Q_W;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StAct
  } state_e;

endpackage

// File: rtl/mac_unit.sv
// Signed Q8.8 x Q8.8 multiplier feeding a registered, sign-extended accumulator.
module mac_unit
  import nn_pkg::*;
#(
  parameter int unsigned ACC_W = 40
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [Q_W-1:0]   weight_i,
  input  logic signed [Q_W-1:0]   data_i,
  output logic signed [ACC_W-1:0] acc_nxt_o
);

  logic signed [2*Q_W-1:0] prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  assign prod     = weight_i * data_i;
  assign prod_ext = ACC_W'(prod);

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // The controller captures the sum on the same edge as the final accumulate.
  assign acc_nxt_o = acc_d;

endmodule

// File: rtl/neuron_mac_controller.sv
// Reads one neuron's weight/input words from ROM, accumulates their products and
// applies a strict greater-than threshold activation.
module neuron_mac_controller
  import nn_pkg::*;
#(
  parameter int unsigned             NUM_INPUTS = 8,
  parameter int unsigned             ADDR_W     = 8,
  parameter int unsigned             BASE_ADDR  = 0,
  parameter int unsigned             ACC_W      = 40,
  parameter logic signed [ACC_W-1:0] THRESHOLD  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [0:WORD_W-1] rom_data,
  input  logic              rom_valid,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  sum,
  output logic              neuron_out
);

  localparam int unsigned      CNT_W      = $clog2(NUM_INPUTS + 1);
  localparam logic [CNT_W-1:0] LAST_ISSUE = CNT_W'(NUM_INPUTS - 1);
  localparam logic [CNT_W-1:0] NUM_WORDS  = CNT_W'(NUM_INPUTS);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]        recv_cnt_q, recv_cnt_d;
  logic [ACC_W-1:0]        sum_q, sum_d;
  logic                    nout_q, nout_d;
  logic                    clr;
  logic                    accept;
  logic signed [ACC_W-1:0] acc_nxt;

  assign busy     = (state_q == StFetch) || (state_q == StDrain);
  assign rom_rd   = (state_q == StFetch);
  assign rom_addr = rom_rd ? (ADDR_W'(BASE_ADDR) + ADDR_W'(issue_cnt_q)) : '0;
  assign done     = (state_q == StAct);
  assign sum      = sum_q;
  assign neuron_out = nout_q;

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    sum_d       = sum_q;
    nout_d      = nout_q;
    clr         = 1'b0;
    // Words beyond the burst length are dropped.
    accept      = busy && rom_valid && (recv_cnt_q < NUM_WORDS);
    if (accept) begin
      recv_cnt_d = recv_cnt_q + 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StFetch;
          clr         = 1'b1;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          sum_d       = '0;
          nout_d      = 1'b0;
        end
      end
      StFetch: begin
        issue_cnt_d = issue_cnt_q + 1'b1;
        if (issue_cnt_q == LAST_ISSUE) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (recv_cnt_d == NUM_WORDS) begin
          state_d = StAct;
          sum_d   = acc_nxt;
          nout_d  = acc_nxt > THRESHOLD;
        end
      end
      StAct: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      sum_q       <= '0;
      nout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      sum_q       <= sum_d;
      nout_q      <= nout_d;
    end
  end

  mac_unit #(
    .ACC_W(ACC_W)
  ) u_mac (
    .clk_i    (clk),
    .rst_ni   (reset),
    .clr_i    (clr),
    .en_i     (accept),
    .weight_i (rom_data[WEIGHT_POS +: Q_W]),
    .data_i   (rom_data[INPUT_POS +: Q_W]),
    .acc_nxt_o(acc_nxt)
  );

endmodule

// File: tb/tb_neuron_mac_controller.sv
// Bench for neuron_mac_controller: a ROM model with one-cycle latency and optional stalls,
// a second instance with a raised threshold and offset base address sharing the stimulus.
module tb_neuron_mac_controller;

  localparam int unsigned N       = 4;
  localparam int unsigned ACC_W   = 40;
  localparam logic [7:0]  TH_BASE = 8'h10;

  typedef logic [N-1:0][15:0] lane_t;

  typedef struct {
    lane_t       w;
    lane_t       x;
    logic [39:0] exp_sum;
    logic        exp_n;
    logic        exp_nt;
    int          stall_after;
    int          stall_len;
    int          busy_start;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, start, rom_valid;
  logic [31:0] rom_data;
  logic        rom_rd, busy, done, nout;
  logic [7:0]  rom_addr;
  logic [39:0] sum;
  logic        rom_rd_t, busy_t, done_t, nout_t;
  logic [7:0]  rom_addr_t;
  logic [39:0] sum_t;
  logic [31:0] mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  neuron_mac_controller #(
    .NUM_INPUTS(N), .ADDR_W(8), .BASE_ADDR(0), .ACC_W(ACC_W), .THRESHOLD(40'sh0)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rom_data(rom_data), .rom_valid(rom_valid),
    .rom_rd(rom_rd), .rom_addr(rom_addr), .busy(busy), .done(done), .sum(sum),
    .neuron_out(nout)
  );

  neuron_mac_controller #(
    .NUM_INPUTS(N), .ADDR_W(8), .BASE_ADDR(32'h10), .ACC_W(ACC_W), .THRESHOLD(40'sh8_0000)
  ) dut_th (
    .clk(clk), .reset(reset), .start(start), .rom_data(rom_data), .rom_valid(rom_valid),
    .rom_rd(rom_rd_t), .rom_addr(rom_addr_t), .busy(busy_t), .done(done_t), .sum(sum_t),
    .neuron_out(nout_t)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic longint model_sum(input lane_t w, input lane_t x);
    longint s;
    s = 0;
    for (int i = 0; i < N; i++) begin
      s += longint'($signed(w[i])) * longint'($signed(x[i]));
    end
    return s;
  endfunction

  // Starts a burst from IDLE, serves reads, checks the result, and returns one cycle
  // after done so a following call starts back-to-back.
  task automatic run_burst(input string nm, input lane_t w, input lane_t x,
                           input logic [39:0] exp_sum, input logic exp_n, input logic exp_nt,
                           input int stall_after, input int stall_len, input int busy_start,
                           input logic act_start);
    int          got, rd_cnt, stall_left, done_cyc;
    logic        seen;
    logic [7:0]  exp_addr;
    logic [31:0] q[$];
    for (int i = 0; i < N; i++) mem[i] = {w[i], x[i]};
    got = 0; rd_cnt = 0; stall_left = 0; done_cyc = -1; seen = 1'b0; exp_addr = 8'h0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, " sum_cleared"}, 64'(sum), 64'(0));
    chk({nm, " busy_c0"}, 64'(busy), 64'(1));
    for (int c = 0; c < 40 && !seen; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      start = (c == busy_start);
      if (stall_left > 0) begin
        rom_valid = 1'b0;
        stall_left--;
      end else if (q.size() > 0) begin
        rom_data  = q.pop_front();
        rom_valid = 1'b1;
        got++;
        if (got == stall_after) stall_left = stall_len;
      end else begin
        rom_valid = 1'b0;
      end
      if (rom_rd) begin
        chk({nm, " addr"}, 64'(rom_addr), 64'(exp_addr));
        chk({nm, " addr_th"}, 64'(rom_addr_t), 64'(exp_addr + TH_BASE));
        q.push_back(mem[rom_addr]);
        exp_addr++;
        rd_cnt++;
      end
      if (done) begin
        seen     = 1'b1;
        done_cyc = c;
        chk({nm, " sum"}, 64'(sum), 64'(exp_sum));
        chk({nm, " neuron_out"}, 64'(nout), 64'(exp_n));
        chk({nm, " sum_th"}, 64'(sum_t), 64'(exp_sum));
        chk({nm, " neuron_out_th"}, 64'(nout_t), 64'(exp_nt));
        chk({nm, " done_th"}, 64'(done_t), 64'(1));
        chk({nm, " busy_at_done"}, 64'(busy), 64'(0));
      end
    end
    rom_valid = 1'b0;
    start     = 1'b0;
    chk({nm, " done_seen"}, 64'(seen), 64'(1));
    chk({nm, " latency"}, 64'(done_cyc), 64'(N + 1 + stall_len));
    chk({nm, " reads"}, 64'(rd_cnt), 64'(N));
    if (act_start) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, " done_pulse"}, 64'(done), 64'(0));
    chk({nm, " idle_after"}, 64'(busy), 64'(0));
    chk({nm, " sum_hold"}, 64'(sum), 64'(exp_sum));
    chk({nm, " nout_hold"}, 64'(nout), 64'(exp_n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t   vecs[6];
    lane_t  rw, rx;
    longint s;
    reset = 1'b0; start = 1'b0; rom_valid = 1'b0; rom_data = 32'h0;
    #1;
    chk("rst rom_rd", 64'(rom_rd), 64'(0));
    chk("rst rom_addr", 64'(rom_addr), 64'(0));
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst done", 64'(done), 64'(0));
    chk("rst sum", 64'(sum), 64'(0));
    chk("rst nout", 64'(nout), 64'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    vecs[0] = '{w: {4{16'h0100}}, x: {4{16'h0200}}, exp_sum: 40'h00_0008_0000,
                exp_n: 1'b1, exp_nt: 1'b0, stall_after: 0, stall_len: 0, busy_start: -1};
    vecs[1] = '{w: {4{16'hFF00}}, x: {4{16'h0100}}, exp_sum: 40'hFF_FFFC_0000,
                exp_n: 1'b0, exp_nt: 1'b0, stall_after: 0, stall_len: 0, busy_start: -1};
    vecs[2] = '{w: {4{16'h0100}}, x: {4{16'h0200}}, exp_sum: 40'h00_0008_0000,
                exp_n: 1'b1, exp_nt: 1'b0, stall_after: 2, stall_len: 3, busy_start: -1};
    vecs[3] = '{w: {4{16'h0100}}, x: {4{16'h0200}}, exp_sum: 40'h00_0008_0000,
                exp_n: 1'b1, exp_nt: 1'b0, stall_after: 0, stall_len: 0, busy_start: 2};
    // 0.5*4 - 0.5*2 - 3*1 + tiny
    vecs[4] = '{w: {16'h0080, 16'hFF80, 16'h0300, 16'h0001},
                x: {16'h0400, 16'h0200, 16'hFF00, 16'h0001}, exp_sum: 40'hFF_FFFE_0001,
                exp_n: 1'b0, exp_nt: 1'b0, stall_after: 0, stall_len: 0, busy_start: -1};
    vecs[5] = '{w: {4{16'h0100}}, x: {16'h0200, 16'h0200, 16'h0200, 16'h0201},
                exp_sum: 40'h00_0008_0100, exp_n: 1'b1, exp_nt: 1'b1,
                stall_after: 1, stall_len: 1, busy_start: -1};

    for (int i = 0; i < 6; i++) begin
      run_burst($sformatf("vec%0d", i), vecs[i].w, vecs[i].x, vecs[i].exp_sum,
                vecs[i].exp_n, vecs[i].exp_nt, vecs[i].stall_after, vecs[i].stall_len,
                vecs[i].busy_start, i == 1);
    end

    // Reset in the middle of a burst, with ROM data still arriving.
    for (int i = 0; i < N; i++) mem[i] = 32'h0100_0200;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst addr_before", 64'(rom_addr), 64'(3));
    rom_valid = 1'b1;
    rom_data  = 32'h7FFF_7FFF;
    reset     = 1'b0;
    #1;
    chk("midrst rom_rd", 64'(rom_rd), 64'(0));
    chk("midrst rom_addr", 64'(rom_addr), 64'(0));
    chk("midrst busy", 64'(busy), 64'(0));
    chk("midrst done", 64'(done), 64'(0));
    chk("midrst sum", 64'(sum), 64'(0));
    chk("midrst nout", 64'(nout), 64'(0));
    chk("midrst busy_th", 64'(busy_t), 64'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst stray_busy", 64'(busy), 64'(0));
    chk("midrst stray_sum", 64'(sum), 64'(0));
    rom_valid = 1'b0;
    run_burst("post_reset", vecs[0].w, vecs[0].x, vecs[0].exp_sum, 1'b1, 1'b0, 0, 0, -1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      int sa, sl;
      for (int i = 0; i < N; i++) begin
        rw[i] = 16'($urandom);
        rx[i] = 16'($urandom);
      end
      s  = model_sum(rw, rx);
      sa = int'($urandom_range(1, N - 1));
      sl = int'($urandom_range(0, 3));
      run_burst($sformatf("rand%0d", r), rw, rx, s[39:0], s > 0, s > 64'sh8_0000,
                sa, sl, (r == 2) ? 1 : -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
